// File: rtl/jk_pkg.sv
// Shared types for the JK latch command driver: opcodes, FSM states and the
// buffered command record.
package jk_pkg;

  localparam int JK_CNT_W = 8;

  // Encoding matches {J,K} so an opcode can drive the latch inputs directly.
  typedef enum logic [1:0] {
    JK_HOLD = 2'b00,
    JK_CLR  = 2'b01,
    JK_SET  = 2'b10,
    JK_TOG  = 2'b11
  } jk_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SETUP = 2'b01,
    ST_PULSE = 2'b10,
    ST_GAP   = 2'b11
  } jk_drv_state_e;

  typedef struct packed {
    jk_op_e              op;
    logic [JK_CNT_W-1:0] len;
  } jk_cmd_t;

endpackage

// File: rtl/jk_cmd_fifo.sv
// Small synchronous command FIFO with show-ahead read data; wrap detection uses
// one extra pointer bit so full and empty are distinguishable.
module jk_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr_reg;
  logic [AW:0]  rd_ptr_reg;
  logic         do_push;
  logic         do_pop;

  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg[AW-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
    end
  end

endmodule

// File: rtl/jk_cmd_driver.sv
// Plays buffered {op, len} commands into a JK latch as enable pulses, keeping
// J/K stable for a full cycle on each side of every pulse.
module jk_cmd_driver
  import jk_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = JK_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_len,
  output logic             J,
  output logic             K,
  output logic             en,
  output logic             busy,
  output logic             done
);

  localparam int CMD_W = 2 + CNT_W;
  localparam logic [CNT_W-1:0] REM_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  jk_drv_state_e    state_reg, state_next;
  jk_op_e           op_reg, op_next;
  logic [CNT_W-1:0] rem_reg, rem_next;
  logic             j_reg, j_next;
  logic             k_reg, k_next;
  logic             en_reg, en_next;
  logic             done_reg, done_next;

  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CMD_W-1:0] fifo_rdata;
  jk_op_e           head_op;
  logic [CNT_W-1:0] head_len;
  logic             take;

  assign fifo_push = cmd_valid && !fifo_full;
  assign head_op   = jk_op_e'(fifo_rdata[CMD_W-1 -: 2]);
  assign head_len  = fifo_rdata[CNT_W-1:0];

  jk_cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (CMD_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .wdata ({cmd_op, cmd_len}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_next = state_reg;
    op_next    = op_reg;
    rem_next   = rem_reg;
    j_next     = 1'b0;
    k_next     = 1'b0;
    en_next    = 1'b0;
    done_next  = 1'b0;
    fifo_pop   = 1'b0;
    take       = 1'b0;

    case (state_reg)
      ST_IDLE: take = !fifo_empty;
      ST_SETUP: begin
        state_next       = ST_PULSE;
        {j_next, k_next} = op_reg;
        en_next          = 1'b1;
        rem_next         = rem_reg - REM_ONE;
      end
      ST_PULSE: begin
        state_next       = ST_GAP;
        {j_next, k_next} = op_reg;
        done_next        = (rem_reg == '0);
      end
      ST_GAP: begin
        if (rem_reg != '0) begin
          state_next       = ST_PULSE;
          {j_next, k_next} = op_reg;
          en_next          = 1'b1;
          rem_next         = rem_reg - REM_ONE;
        end else begin
          state_next = ST_IDLE;
          take       = !fifo_empty;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // A zero-length command completes straight from IDLE without touching J/K.
    if (take) begin
      fifo_pop = 1'b1;
      op_next  = head_op;
      rem_next = head_len;
      if (head_len != '0) begin
        state_next       = ST_SETUP;
        {j_next, k_next} = head_op;
      end else begin
        state_next = ST_IDLE;
        done_next  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      op_reg    <= JK_HOLD;
      rem_reg   <= '0;
      j_reg     <= 1'b0;
      k_reg     <= 1'b0;
      en_reg    <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      op_reg    <= op_next;
      rem_reg   <= rem_next;
      j_reg     <= j_next;
      k_reg     <= k_next;
      en_reg    <= en_next;
      done_reg  <= done_next;
    end
  end

  assign J         = j_reg;
  assign K         = k_reg;
  assign en        = en_reg;
  assign done      = done_reg;
  assign busy      = (state_reg != ST_IDLE) || !fifo_empty;
  assign cmd_ready = !fifo_full;

endmodule

// File: doc/jk_cmd_driver.md
# jk_cmd_driver

Command sequencer that sits directly upstream of the JK latch and generates its J, K and level-enable inputs. Accepts opcode/repeat-count commands over a valid/ready handshake, buffers them in a small FIFO, and plays each one out as a series of single-cycle enable pulses. J/K are held stable one cycle before and one cycle after every pulse, so a toggle command advances the latch exactly once per pulse.

## Interface
- DEPTH, 4: command FIFO entries; power of two, ≥2
- CNT_W, 8: width of repeat count
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears FSM, FIFO and all outputs
- cmd_valid  in  1  command present
- cmd_ready  out  1  FIFO can accept; = !full
- cmd_op  in  2  jk_op_e: 00 hold, 01 clear, 10 set, 11 toggle (same encoding as {J,K})
- cmd_len  in  CNT_W  number of enable pulses; 0 = no-op
- J  out  1  latch J, registered
- K  out  1  latch K, registered
- en  out  1  latch enable (drives latch clk input), registered
- busy  out  1  FSM not IDLE or FIFO non-empty
- done  out  1  one-cycle pulse when a command completes

## Operation
- Push on edge where cmd_valid && cmd_ready; {cmd_op, cmd_len} written to FIFO.
- Simultaneous push and pop allowed when FIFO non-empty; occupancy unchanged.
- Push when full impossible (cmd_ready low); cmd_valid ignored.
- FSM states: IDLE, SETUP, PULSE, GAP.
- IDLE: J=K=0, en=0. If FIFO non-empty: pop into op/rem registers.
  - len≠0 → SETUP; len=0 → stay IDLE, done=1 next cycle, J/K untouched.
- SETUP (1 cycle): J,K = op; en=0.
- PULSE (1 cycle): J,K = op; en=1; rem decremented.
- GAP (1 cycle): J,K = op; en=0.
  - rem≠0 → PULSE.
  - rem=0: done=1 this cycle; if FIFO non-empty pop → SETUP (or IDLE+done for len=0), else → IDLE.
- Registered outputs: en never high in a cycle where J/K change.
- cmd_len is unsigned; full range 1..2^CNT_W−1 pulses, no wrap.

## Timing
- Reset values: J=0, K=0, en=0, done=0, busy=0, cmd_ready=1, FIFO empty, state IDLE.
- Reset asserted mid-command: en, J, K drop immediately (async); FIFO flushed; no done pulse.
- Cycle n = interval after edge n. Push at edge 0 into empty idle block:
  - cycle 1 IDLE (busy=1), pop at edge 1
  - cycle 2 SETUP with J/K valid
  - en high in cycles 3, 5, …, 3+2(L−1)
  - done in cycle 4+2(L−1), last GAP
- Back-to-back commands: next SETUP immediately after previous GAP; no IDLE cycle between.
- Per command of length L≥1: 2L+1 cycles from SETUP to last GAP inclusive.
- cmd_ready updates in the cycle after a pop or push changes fullness.

## Structure
- Package jk_pkg: typedef enum logic [1:0] jk_op_e {JK_HOLD, JK_CLR, JK_SET, JK_TOG}; FSM state enum jk_drv_state_e; command struct {op, len}.
- Sub-module jk_cmd_fifo: synchronous FIFO, DEPTH entries, push/pop/full/empty, pointer wrap via log2(DEPTH)+1-bit pointers, same async active-high reset.
- Top: FSM, op/rem registers, output registers.

## Test plan
- Reset release, no commands → J=K=en=0, busy=0, cmd_ready=1 indefinitely.
- Push {SET, 1} at edge 0 → J=1,K=0 cycles 2–4; en=1 only in cycle 3; done in cycle 4; then IDLE J=K=0.
- Push {TOG, 3} → en high cycles 3, 5, 7, J=K=1 throughout; latch model shows Q toggling exactly 3 times; done in cycle 8.
- Push 5 × {CLR, 2} with cmd_valid held, DEPTH=4 → cmd_ready drops when 4 entries buffered, recovers after first pop; 5 done pulses, no gap between commands.
- Push {HOLD, 0} then {SET, 1} → first yields done with no en; second plays normally.
- Assert reset during PULSE of {TOG, 4} with 2 queued → en/J/K drop same cycle, busy=0, no done; after release next push plays from SETUP.
